// File: rtl/ras_stack.sv
// Speculative return-address stack with circular overflow and same-cycle call/return.
// Optional macro RAS_REPAIR_EN: restore pointers from the committed shadow on mispredict.
module ras_stack #(
  parameter int Depth     = 8,
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [AddrWidth-1:0] ra_i,
  input  logic                 commit_push_i,
  input  logic                 commit_pop_i,
  input  logic                 mispredict_i,
  output logic                 ras_valid_o,
  output logic [AddrWidth-1:0] ras_ra_o,
  output logic                 overflow_o
);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Depth);

  typedef struct packed {
    logic [PtrW-1:0] tos;
    logic [CntW-1:0] cnt;
  } ptr_t;

  // Shared pointer/count arithmetic for the speculative and committed views.
  function automatic ptr_t ptr_step(input ptr_t cur, input logic psh, input logic pp);
    ptr_t nxt;
    nxt = cur;
    if (psh && (!pp || cur.cnt == '0)) begin
      nxt.tos = cur.tos + PtrW'(1);
      if (cur.cnt != CntMax) nxt.cnt = cur.cnt + CntW'(1);
    end else if (pp && !psh && cur.cnt != '0) begin
      nxt.tos = cur.tos - PtrW'(1);
      nxt.cnt = cur.cnt - CntW'(1);
    end
    return nxt;
  endfunction

  logic [AddrWidth-1:0] stack_q [Depth];
  ptr_t                 spec_q, spec_d, spec_step;
  logic                 wr_en;
  logic [PtrW-1:0]      wr_idx;

`ifdef RAS_REPAIR_EN
  ptr_t commit_q, commit_d;
  assign commit_d = ptr_step(commit_q, commit_push_i, commit_pop_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) commit_q <= '0;
    else         commit_q <= commit_d;
  end
`else
  logic unused_commit;
  assign unused_commit = commit_push_i ^ commit_pop_i;
`endif

  // push+pop on a non-empty stack leaves tos unchanged, so the stepped tos is
  // always the slot a push writes.
  always_comb begin
    spec_step  = ptr_step(spec_q, push_i, pop_i);
    spec_d     = spec_step;
    wr_en      = 1'b0;
    wr_idx     = spec_step.tos;
    overflow_o = 1'b0;
    if (mispredict_i) begin
`ifdef RAS_REPAIR_EN
      spec_d = commit_d;
`else
      spec_d.tos = spec_q.tos;
      spec_d.cnt = '0;
`endif
    end else begin
      wr_en      = push_i;
      overflow_o = push_i && !pop_i && (spec_q.cnt == CntMax);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_q <= '0;
      for (int i = 0; i < Depth; i++) stack_q[i] <= '0;
    end else begin
      spec_q <= spec_d;
      if (wr_en) stack_q[wr_idx] <= ra_i;
    end
  end

  assign ras_valid_o = (spec_q.cnt != '0);
  assign ras_ra_o    = ras_valid_o ? stack_q[spec_q.tos] : '0;

endmodule

// File: tb/tb_ras_stack.sv
// Directed plus randomized bench for ras_stack against an array-based reference model.
module tb_ras_stack;
  localparam int D = 8;

  logic        clk, rst_ni;
  logic        push_i, pop_i, commit_push_i, commit_pop_i, mispredict_i;
  logic [31:0] ra_i;
  logic        ras_valid_o, overflow_o;
  logic [31:0] ras_ra_o;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_stk [D];
  int m_tos, m_cnt, m_ctos, m_ccnt;

  ras_stack #(.Depth(D), .AddrWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .push_i(push_i), .pop_i(pop_i), .ra_i(ra_i),
    .commit_push_i(commit_push_i), .commit_pop_i(commit_pop_i),
    .mispredict_i(mispredict_i), .ras_valid_o(ras_valid_o),
    .ras_ra_o(ras_ra_o), .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_stk[i] = '0;
    m_tos = 0; m_cnt = 0; m_ctos = 0; m_ccnt = 0;
  endtask

  function automatic logic [31:0] m_ra();
    return (m_cnt != 0) ? m_stk[m_tos] : 32'h0;
  endfunction

  task automatic model_clock(input logic p, q, input logic [31:0] ra,
                             input logic cp, cq, m);
    int nct, ncc;
    nct = m_ctos; ncc = m_ccnt;
    if (cp && (!cq || m_ccnt == 0)) begin
      nct = (m_ctos + 1) % D;
      ncc = (m_ccnt == D) ? D : m_ccnt + 1;
    end else if (cq && !cp && m_ccnt > 0) begin
      nct = (m_ctos + D - 1) % D;
      ncc = m_ccnt - 1;
    end
    if (m) begin
`ifdef RAS_REPAIR_EN
      m_tos = nct; m_cnt = ncc;
`else
      m_cnt = 0;
`endif
    end else if (p && (!q || m_cnt == 0)) begin
      m_tos = (m_tos + 1) % D;
      m_stk[m_tos] = ra;
      m_cnt = (m_cnt == D) ? D : m_cnt + 1;
    end else if (p && q) begin
      m_stk[m_tos] = ra;
    end else if (q && m_cnt > 0) begin
      m_tos = (m_tos + D - 1) % D;
      m_cnt = m_cnt - 1;
    end
    m_ctos = nct; m_ccnt = ncc;
  endtask

  // One clock: drive, check combinational overflow, clock, check registered outputs.
  task automatic cyc(input logic p, q, input logic [31:0] ra,
                     input logic cp, cq, m);
    logic exp_ovf;
    push_i = p; pop_i = q; ra_i = ra;
    commit_push_i = cp; commit_pop_i = cq; mispredict_i = m;
    #1;
    exp_ovf = !m && p && !q && (m_cnt == D);
    chk("overflow", {31'b0, overflow_o}, {31'b0, exp_ovf});
    @(posedge clk);
    model_clock(p, q, ra, cp, cq, m);
    #1;
    chk("valid", {31'b0, ras_valid_o}, {31'b0, (m_cnt != 0)});
    chk("ra", ras_ra_o, m_ra());
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 1'b0; push_i = 0; pop_i = 0; ra_i = '0;
    commit_push_i = 0; commit_pop_i = 0; mispredict_i = 0;
    model_reset();
    #1;
    chk("rst_valid", {31'b0, ras_valid_o}, 32'h0);
    chk("rst_ra", ras_ra_o, 32'h0);
    chk("rst_ovf", {31'b0, overflow_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    // Basic push/pop
    cyc(1, 0, 32'h8000_0010, 0, 0, 0);
    cyc(1, 0, 32'h8000_0020, 0, 0, 0);
    chk("basic_top", ras_ra_o, 32'h8000_0020);
    cyc(0, 1, 32'h0, 0, 0, 0);
    chk("basic_pop1", ras_ra_o, 32'h8000_0010);
    cyc(0, 1, 32'h0, 0, 0, 0);
    chk("basic_empty", {31'b0, ras_valid_o}, 32'h0);

    // Overflow on the ninth push, then drain
    for (int i = 1; i <= 9; i++) begin
      push_i = 1; pop_i = 0; ra_i = 32'(i * 32'h100);
      #1;
      chk("ovf_direct", {31'b0, overflow_o}, {31'b0, (i == 9)});
      @(negedge clk);
      model_clock(1, 0, 32'(i * 32'h100), 0, 0, 0);
    end
    push_i = 0;
    chk("ovf_top", ras_ra_o, 32'h900);
    for (int i = 9; i >= 2; i--) begin
      chk("drain", ras_ra_o, 32'(i * 32'h100));
      cyc(0, 1, 32'h0, 0, 0, 0);
    end
    chk("drain_empty", {31'b0, ras_valid_o}, 32'h0);
    cyc(0, 1, 32'h0, 0, 0, 0);
    chk("pop_empty_ignored", {31'b0, ras_valid_o}, 32'h0);

    // Push+pop replaces top; on an empty stack it pushes
    cyc(1, 0, 32'h90, 0, 0, 0);
    cyc(1, 0, 32'hA0, 0, 0, 0);
    cyc(1, 1, 32'hB0, 0, 0, 0);
    chk("pp_replace", ras_ra_o, 32'hB0);
    cyc(0, 1, 32'h0, 0, 0, 0);
    chk("pp_cnt_kept", ras_ra_o, 32'h90);
    cyc(0, 1, 32'h0, 0, 0, 0);
    cyc(1, 1, 32'hC0, 0, 0, 0);
    chk("pp_empty_valid", {31'b0, ras_valid_o}, 32'h1);
    chk("pp_empty_ra", ras_ra_o, 32'hC0);

    // Asynchronous reset with five entries live
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'(32'h500 + i), 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    chk("async_valid", {31'b0, ras_valid_o}, 32'h0);
    chk("async_ra", ras_ra_o, 32'h0);
    #1 rst_ni = 1'b1;
    @(negedge clk);

    // Mispredict repair sequence
    cyc(1, 0, 32'h10, 0, 0, 0);
    cyc(1, 0, 32'h20, 1, 0, 0);
    cyc(1, 0, 32'h30, 1, 0, 0);
    cyc(0, 1, 32'h0, 0, 0, 0);
    cyc(0, 1, 32'h0, 0, 0, 0);
    cyc(1, 0, 32'hEE, 0, 1, 1);
`ifdef RAS_REPAIR_EN
    chk("repair_valid", {31'b0, ras_valid_o}, 32'h1);
    chk("repair_ra", ras_ra_o, 32'h10);
`else
    chk("flush_valid", {31'b0, ras_valid_o}, 32'h0);
    cyc(1, 0, 32'h40, 0, 0, 0);
    chk("flush_push", ras_ra_o, 32'h40);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic rp, rq, rcp, rcq, rm;
      rp  = ($urandom_range(0, 99) < 55);
      rq  = ($urandom_range(0, 99) < 40);
      rcp = ($urandom_range(0, 99) < 30);
      rcq = ($urandom_range(0, 99) < 25);
      rm  = ($urandom_range(0, 99) < 5);
      cyc(rp, rq, $urandom, rcp, rcq, rm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
